imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 15 +
 rtl/imem_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The frame layout is: 16-bit little-endian word count, packed data words, then an XOR checksum byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } loader_state_t;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;

    // States that take a byte from the host stream
    function automatic logic accepts(loader_state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream in, instruction-RAM write port out.
// The master side is the loader; the slave side is the host link together with the RAM.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;

    modport master (input in_valid, in_data,
                    output in_ready, mem_we, mem_addr, mem_wd);
    modport slave  (output in_valid, in_data,
                    input in_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: checks the frame header and checksum, assembles little-endian words,
// writes them to instruction RAM, and keeps the CPU in reset until a load completes cleanly.
import imem_loader_pkg::*;

module imem_loader #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    imem_loader_if.master bus
);

    loader_state_t state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    chk_q, chk_d;
    logic          in_ready_q, mem_we_q, busy_q, done_q, err_q, cpu_hold_q;
    logic          hs;
    logic [15:0]   cnt_full;

    // in_ready_q already equals accepts(state_q), so the handshake uses registered state only
    assign hs       = bus.in_valid && in_ready_q;
    assign cnt_full = {bus.in_data, cnt_q[7:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        chk_d      = chk_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    chk_d      = '0;
                end
            end
            S_HDR0: begin
                if (hs) begin
                    cnt_d[7:0] = bus.in_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (hs) begin
                    cnt_d = cnt_full;
                    if (cnt_full > 16'(DEPTH))  state_d = S_ERR;
                    else if (cnt_full == 16'd0) state_d = S_CHK;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hs) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                    chk_d      = chk_q ^ bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + AW'(1);
                state_d    = (16'(word_idx_q) == cnt_q - 16'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (hs) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            chk_q      <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            in_ready_q <= accepts(state_d);
            mem_we_q   <= (state_d == S_WRITE);
            busy_q     <= accepts(state_d) || (state_d == S_WRITE);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
            cpu_hold_q <= (state_d != S_DONE);
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = {{(30 - AW){1'b0}}, word_idx_q, 2'b00};
    assign bus.mem_wd   = word_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_hold     = cpu_hold_q;

endmodule
